// File: rtl/johnson_sequence_monitor.sv
// Checks a 4-bit Johnson counter against its 8-state sequence.
// Tracks lock, counts revolutions and logs sequencing faults.
module johnson_sequence_monitor #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned REV_WIDTH  = 16,
  parameter int unsigned ERR_WIDTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [3:0]           ring_in_i,
  input  logic                 clr_i,
  output logic [2:0]           phase_o,
  output logic                 phase_valid_o,
  output logic                 locked_o,
  output logic                 err_pulse_o,
  output logic                 err_sticky_o,
  output logic [REV_WIDTH-1:0] rev_count_o,
  output logic [ERR_WIDTH-1:0] err_count_o
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  localparam logic [3:0]           LOCK_TGT = LOCK_COUNT[3:0];
  localparam logic [ERR_WIDTH-1:0] ERR_MAX  = {ERR_WIDTH{1'b1}};
  localparam logic [ERR_WIDTH-1:0] ERR_ONE  = {{(ERR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REV_WIDTH-1:0] REV_ONE  = {{(REV_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic code_legal(input logic [3:0] c);
    logic ok;
    case (c)
      4'b0000, 4'b0001, 4'b0011, 4'b0111,
      4'b1111, 4'b1110, 4'b1100, 4'b1000: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] code_idx(input logic [3:0] c);
    logic [2:0] idx;
    case (c)
      4'b0001: idx = 3'd1;
      4'b0011: idx = 3'd2;
      4'b0111: idx = 3'd3;
      4'b1111: idx = 3'd4;
      4'b1110: idx = 3'd5;
      4'b1100: idx = 3'd6;
      4'b1000: idx = 3'd7;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  state_e                 state_q, state_d;
  logic [3:0]             good_cnt_q, good_cnt_d;
  logic                   en_q;
  logic [2:0]             phase_q, phase_d;
  logic                   phase_valid_q;
  logic                   locked_q, locked_d;
  logic                   err_pulse_q, err_pulse_d;
  logic                   err_sticky_q, err_sticky_d;
  logic [REV_WIDTH-1:0]   rev_q, rev_d;
  logic [ERR_WIDTH-1:0]   err_cnt_q, err_cnt_d;

  logic                   s_legal;
  logic [2:0]             s_idx;
  logic [2:0]             exp_idx;
  logic                   correct;
  logic                   fault;
  logic                   wrap;
  logic [3:0]             good_inc;

  // Next-state decode: step check, lock FSM, revolution and fault counters
  always_comb begin
    s_legal      = code_legal(ring_in_i);
    s_idx        = code_idx(ring_in_i);
    // With the counter held the code must repeat; otherwise it must advance by one
    exp_idx      = en_q ? (phase_q + 3'd1) : phase_q;
    correct      = phase_valid_q & s_legal & (s_idx == exp_idx);
    good_inc     = good_cnt_q + 4'd1;
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    fault        = 1'b0;
    wrap         = 1'b0;

    case (state_q)
      ST_UNLOCKED: begin
        if (s_legal) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = 4'd0;
        end else begin
          state_d    = ST_UNLOCKED;
        end
      end
      ST_ACQUIRE: begin
        if (!s_legal) begin
          state_d    = ST_UNLOCKED;
        end else if (correct) begin
          good_cnt_d = good_inc;
          state_d    = (good_inc == LOCK_TGT) ? ST_LOCKED : ST_ACQUIRE;
        end else begin
          good_cnt_d = 4'd0;
        end
      end
      ST_LOCKED: begin
        if (!correct) begin
          state_d = ST_FAULT;
          fault   = 1'b1;
        end else begin
          wrap    = (phase_q == 3'd7) && (s_idx == 3'd0);
        end
      end
      ST_FAULT: begin
        if (s_legal) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = 4'd0;
        end else begin
          state_d    = ST_UNLOCKED;
        end
      end
      default: begin
        state_d    = ST_UNLOCKED;
        good_cnt_d = 4'd0;
      end
    endcase

    phase_d     = s_legal ? s_idx : phase_q;
    locked_d    = (state_d == ST_LOCKED);
    err_pulse_d = fault;

    // Clear applies first so a coincident event still lands in the fresh count
    rev_d        = clr_i ? '0 : rev_q;
    err_cnt_d    = clr_i ? '0 : err_cnt_q;
    err_sticky_d = clr_i ? 1'b0 : err_sticky_q;
    if (wrap) begin
      rev_d = rev_d + REV_ONE;
    end else begin
      rev_d = rev_d;
    end
    if (fault) begin
      err_sticky_d = 1'b1;
      err_cnt_d    = (err_cnt_d == ERR_MAX) ? ERR_MAX : (err_cnt_d + ERR_ONE);
    end else begin
      err_sticky_d = err_sticky_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_UNLOCKED;
      good_cnt_q    <= 4'd0;
      en_q          <= 1'b0;
      phase_q       <= 3'd0;
      phase_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      rev_q         <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      en_q          <= en_i;
      phase_q       <= phase_d;
      phase_valid_q <= s_legal;
      locked_q      <= locked_d;
      err_pulse_q   <= err_pulse_d;
      err_sticky_q  <= err_sticky_d;
      rev_q         <= rev_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign phase_o       = phase_q;
  assign phase_valid_o = phase_valid_q;
  assign locked_o      = locked_q;
  assign err_pulse_o   = err_pulse_q;
  assign err_sticky_o  = err_sticky_q;
  assign rev_count_o   = rev_q;
  assign err_count_o   = err_cnt_q;

endmodule

// File: tb/tb_johnson_sequence_monitor.sv
// Bench for johnson_sequence_monitor: a rule-level model checked every cycle,
// plus hand-computed literal expectations along a directed scenario.
module tb_johnson_sequence_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  ring_in = 4'd0;
  logic        clr = 1'b0;
  logic [2:0]  phase;
  logic        phase_valid, locked, err_pulse, err_sticky;
  logic [15:0] rev_count;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;
  logic [3:0] jc;

  johnson_sequence_monitor #(.LOCK_COUNT(4), .REV_WIDTH(16), .ERR_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .ring_in_i(ring_in), .clr_i(clr),
    .phase_o(phase), .phase_valid_o(phase_valid), .locked_o(locked),
    .err_pulse_o(err_pulse), .err_sticky_o(err_sticky),
    .rev_count_o(rev_count), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  // Model: mode 0 unlocked, 1 acquiring, 2 locked, 3 fault
  logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};
  int m_mode, m_streak, m_phase, m_rev, m_err;
  bit m_pv, m_en_prev, m_locked, m_pulse, m_sticky;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_streak = 0; m_phase = 0; m_rev = 0; m_err = 0;
      m_pv = 0; m_en_prev = 0; m_locked = 0; m_pulse = 0; m_sticky = 0;
    end else begin
      int idx, want;
      bit good, flt, wrp;
      idx = -1;
      for (int i = 0; i < 8; i++) if (codes[i] == ring_in) idx = i;
      want = m_en_prev ? (m_phase + 1) % 8 : m_phase;
      good = m_pv && (idx >= 0) && (idx == want);
      flt = 0; wrp = 0;
      if (m_mode == 0) begin
        if (idx >= 0) begin m_mode = 1; m_streak = 0; end
      end else if (m_mode == 1) begin
        if (idx < 0) m_mode = 0;
        else if (good) begin
          m_streak++;
          if (m_streak == 4) m_mode = 2;
        end else m_streak = 0;
      end else if (m_mode == 2) begin
        if (!good) begin m_mode = 3; flt = 1; end
        else wrp = (m_phase == 7 && idx == 0);
      end else begin
        m_streak = 0;
        m_mode = (idx >= 0) ? 1 : 0;
      end
      if (clr) begin m_rev = 0; m_err = 0; m_sticky = 0; end
      if (flt) begin m_sticky = 1; if (m_err < 255) m_err++; end
      if (wrp) m_rev = (m_rev + 1) % 65536;
      m_pulse = flt;
      m_locked = (m_mode == 2);
      m_pv = (idx >= 0);
      if (idx >= 0) m_phase = idx;
      m_en_prev = en;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (started) begin
      logic [30:0] act, exp;
      act = {phase, phase_valid, locked, err_pulse, err_sticky, rev_count, err_count};
      exp = {m_phase[2:0], m_pv, m_locked, m_pulse, m_sticky, m_rev[15:0], m_err[7:0]};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL model_cmp t=%0t got ph=%0d pv=%0b lk=%0b ep=%0b es=%0b rev=%0d err=%0d want ph=%0d pv=%0b lk=%0b ep=%0b es=%0b rev=%0d err=%0d",
                 $time, phase, phase_valid, locked, err_pulse, err_sticky, rev_count, err_count,
                 m_phase, m_pv, m_locked, m_pulse, m_sticky, m_rev, m_err);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic e, input logic c);
    @(negedge clk);
    ring_in = jc; en = e; clr = c;
    @(posedge clk); #1;
    if (e) jc = {jc[2:0], ~jc[3]};
  endtask

  task automatic inject(input logic [3:0] code, input logic e, input logic c);
    @(negedge clk);
    ring_in = code; en = e; clr = c;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    started = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ring_in = 4'($urandom); en = 1'($urandom); clr = 1'($urandom);
    end
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_pv", phase_valid, 0);
    chk("rst_err", err_count, 0);
    chk("rst_rev", rev_count, 0);
    @(negedge clk); clr = 1'b0; rst_n = 1'b1;

    // Preset 0001 and count: lock on the 5th legal sample
    jc = 4'b0001;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    chk("acq_not_locked", locked, 0);
    chk("acq_phase", phase, 4);
    tick(1'b1, 1'b0);
    chk("lock_5th", locked, 1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    chk("rev_first", rev_count, 1);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    chk("rev_second", rev_count, 2);

    // Hold with en low while locked
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    chk("hold_phase", phase, 1);
    chk("hold_locked", locked, 1);
    chk("hold_sticky", err_sticky, 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("resume_phase", phase, 2);

    // Illegal code while locked at 0011
    inject(4'b0101, 1'b1, 1'b0);
    chk("ill_pulse", err_pulse, 1);
    chk("ill_cnt", err_count, 1);
    chk("ill_locked", locked, 0);
    tick(1'b1, 1'b0);
    chk("ill_pulse_once", err_pulse, 0);
    chk("ill_sticky", err_sticky, 1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    chk("relock_early", locked, 0);
    tick(1'b1, 1'b0);
    chk("relock", locked, 1);

    // Legal but wrong step while locked, then while acquiring
    tick(1'b1, 1'b0);
    chk("rev_third", rev_count, 3);
    tick(1'b1, 1'b0);
    inject(4'b0111, 1'b1, 1'b0);
    chk("skip_pulse", err_pulse, 1);
    chk("skip_cnt", err_count, 2);
    jc = 4'b1111;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    inject(4'b0000, 1'b1, 1'b0);
    chk("acq_skip_nopulse", err_pulse, 0);
    chk("acq_skip_cnt", err_count, 2);
    jc = 4'b0001;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    chk("restart_early", locked, 0);
    tick(1'b1, 1'b0);
    chk("restart_lock", locked, 1);

    // Clear coincident with a fault, then saturate the error count
    inject(4'b0101, 1'b1, 1'b1);
    chk("clr_fault_cnt", err_count, 1);
    chk("clr_fault_sticky", err_sticky, 1);
    chk("clr_rev", rev_count, 0);
    for (int n = 0; n < 299; n++) begin
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      inject(4'b0101, 1'b1, 1'b0);
    end
    chk("sat_cnt", err_count, 255);
    chk("sat_pulse", err_pulse, 1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("clr_cnt", err_count, 0);
    chk("clr_sticky", err_sticky, 0);
    chk("clr_keeps_lock", locked, 1);

    // Asynchronous reset mid-operation
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("arst_locked", locked, 0);
    chk("arst_phase", phase, 0);
    @(negedge clk); rst_n = 1'b1;
    tick(1'b1, 1'b0);
    chk("reacq_pv", phase_valid, 1);
    chk("reacq_unlocked", locked, 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
